// File: rtl/clk_div_monitor_if.sv
// Signal bundle between a divided-clock source/consumer and clk_div_monitor.
// The master side drives the clock under test and expectations; the slave side is the monitor.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] exp_high;
    logic [CNT_W-1:0] exp_low;
    logic             clr_err;
    logic [CNT_W-1:0] meas_high;
    logic [CNT_W-1:0] meas_low;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic             stuck;

    modport master (
        output en, sig_in, exp_high, exp_low, clr_err,
        input  meas_high, meas_low, period_vld, locked, err, err_count, stuck
    );

    modport slave (
        input  en, sig_in, exp_high, exp_low, clr_err,
        output meas_high, meas_low, period_vld, locked, err, err_count, stuck
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures high/low widths of one divided clock in clk_in cycles and checks them against
// expected widths, reporting lock, sticky mismatch errors and stuck-signal timeouts.
module clk_div_monitor #(
    parameter int CNT_W   = 8,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 200
) (
    input  logic                 clk_in,
    input  logic                 rst,
    clk_div_monitor_if.slave     mon
);
    localparam int GoodW = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [GoodW-1:0] LockVal    = GoodW'(LOCK_N);
    localparam logic [GoodW-1:0] GoodOne    = GoodW'(1);

    typedef enum logic [1:0] {IDLE, SYNC, MEAS_HIGH, MEAS_LOW} state_t;

    state_t           state_q, state_d;
    logic             sig_q;
    logic [CNT_W-1:0] hCnt_q, hCnt_d;
    logic [CNT_W-1:0] lCnt_q, lCnt_d;
    logic [CNT_W-1:0] hLat_q, hLat_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [CNT_W-1:0] measHigh_q, measHigh_d;
    logic [CNT_W-1:0] measLow_q, measLow_d;
    logic             periodVld_q, periodVld_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] errCount_q, errCount_d;
    logic             stuck_q, stuck_d;
    logic             rise, fall, match;

    assign rise  = mon.sig_in & ~sig_q;
    assign fall  = ~mon.sig_in & sig_q;
    assign match = (hLat_q == mon.exp_high) && (lCnt_q == mon.exp_low);

    always_comb begin
        state_d     = state_q;
        hCnt_d      = hCnt_q;
        lCnt_d      = lCnt_q;
        hLat_d      = hLat_q;
        good_d      = good_q;
        measHigh_d  = measHigh_q;
        measLow_d   = measLow_q;
        periodVld_d = 1'b0;
        locked_d    = locked_q;
        err_d       = err_q;
        errCount_d  = errCount_q;
        stuck_d     = stuck_q;

        // Clear first so that a mismatch or timeout on the same edge overrides it.
        if (mon.clr_err) begin
            err_d      = 1'b0;
            errCount_d = '0;
            stuck_d    = 1'b0;
        end

        if (!mon.en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            good_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;
                SYNC: begin
                    if (rise) begin
                        hCnt_d  = CntOne;
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        hLat_d  = hCnt_q;
                        lCnt_d  = CntOne;
                        state_d = MEAS_LOW;
                    end else if (hCnt_q >= TimeoutVal) begin
                        stuck_d  = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = SYNC;
                    end else if (hCnt_q != CntMax) begin
                        hCnt_d = hCnt_q + CntOne;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        measHigh_d  = hLat_q;
                        measLow_d   = lCnt_q;
                        periodVld_d = 1'b1;
                        hCnt_d      = CntOne;
                        state_d     = MEAS_HIGH;
                        if (match) begin
                            if (good_q != LockVal) begin
                                good_d = good_q + GoodOne;
                            end
                            locked_d = locked_q | (good_d == LockVal);
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                            err_d    = 1'b1;
                            if (errCount_d != CntMax) begin
                                errCount_d = errCount_d + CntOne;
                            end
                        end
                    end else if (lCnt_q >= TimeoutVal) begin
                        stuck_d  = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = SYNC;
                    end else if (lCnt_q != CntMax) begin
                        lCnt_d = lCnt_q + CntOne;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            sig_q       <= 1'b0;
            hCnt_q      <= '0;
            lCnt_q      <= '0;
            hLat_q      <= '0;
            good_q      <= '0;
            measHigh_q  <= '0;
            measLow_q   <= '0;
            periodVld_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            errCount_q  <= '0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= mon.sig_in;
            hCnt_q      <= hCnt_d;
            lCnt_q      <= lCnt_d;
            hLat_q      <= hLat_d;
            good_q      <= good_d;
            measHigh_q  <= measHigh_d;
            measLow_q   <= measLow_d;
            periodVld_q <= periodVld_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            errCount_q  <= errCount_d;
            stuck_q     <= stuck_d;
        end
    end

    assign mon.meas_high  = measHigh_q;
    assign mon.meas_low   = measLow_q;
    assign mon.period_vld = periodVld_q;
    assign mon.locked     = locked_q;
    assign mon.err        = err_q;
    assign mon.err_count  = errCount_q;
    assign mon.stuck      = stuck_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Drives divided-clock waveforms into clk_div_monitor and compares every output each cycle
// against a timestamp-based reference model of the width measurement rules.
module tb_clk_div_monitor;
    localparam int CNT_W   = 8;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 200;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clkIn = 1'b0;
    logic rstIn;
    always #5 clkIn = ~clkIn;

    clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

    clk_div_monitor #(
        .CNT_W  (CNT_W),
        .LOCK_N (LOCK_N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in(clkIn),
        .rst   (rstIn),
        .mon   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int genCnt = 0;

    // Reference model: the signal is described by the cycle numbers of its last rise and fall.
    int mMode = 0;
    int riseCyc = 0, fallCyc = 0;
    bit inLow = 0, prevSig = 0;
    int mMH = 0, mML = 0, mPv = 0, mLocked = 0, mErr = 0, mCnt = 0, mStuck = 0, mGood = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic completePeriod(input int hw, input int lw);
        mMH = (hw > SAT) ? SAT : hw;
        mML = (lw > SAT) ? SAT : lw;
        mPv = 1;
        if (mMH == int'(bus.exp_high) && mML == int'(bus.exp_low)) begin
            mGood   = (mGood + 1 > LOCK_N) ? LOCK_N : mGood + 1;
            mLocked = (mGood == LOCK_N) ? 1 : mLocked;
        end else begin
            mGood   = 0;
            mLocked = 0;
            mErr    = 1;
            mCnt    = (mCnt + 1 > SAT) ? SAT : mCnt + 1;
        end
    endtask

    task automatic modelStep();
        bit s, rise, fall;
        s = bus.sig_in;
        if (rstIn) begin
            mMode = 0; prevSig = 0; inLow = 0;
            mMH = 0; mML = 0; mPv = 0; mLocked = 0; mErr = 0; mCnt = 0; mStuck = 0; mGood = 0;
            return;
        end
        rise = s && !prevSig;
        fall = !s && prevSig;
        mPv = 0;
        if (bus.clr_err) begin
            mErr = 0; mCnt = 0; mStuck = 0;
        end
        if (!bus.en) begin
            mMode = 0; mGood = 0; mLocked = 0;
        end else if (mMode == 0) begin
            mMode = 1;
        end else if (mMode == 1) begin
            if (rise) begin
                mMode = 2; riseCyc = cyc; inLow = 0;
            end
        end else begin
            if (inLow && rise) begin
                completePeriod(fallCyc - riseCyc, cyc - fallCyc);
                riseCyc = cyc; inLow = 0;
            end else if (!inLow && fall) begin
                fallCyc = cyc; inLow = 1;
            end else if (cyc - (inLow ? fallCyc : riseCyc) >= TIMEOUT) begin
                mStuck = 1; mLocked = 0; mGood = 0; mMode = 1;
            end
        end
        prevSig = s;
    endtask

    task automatic applyStimulus();
        @(posedge clkIn);
        modelStep();
        cyc++;
        @(negedge clkIn);
        checkOutput("meas_high", bus.meas_high, mMH);
        checkOutput("meas_low", bus.meas_low, mML);
        checkOutput("period_vld", bus.period_vld, mPv);
        checkOutput("locked", bus.locked, mLocked);
        checkOutput("err", bus.err, mErr);
        checkOutput("err_count", bus.err_count, mCnt);
        checkOutput("stuck", bus.stuck, mStuck);
    endtask

    // Runs n cycles of a divider with h high and l low cycles; clrPct is the clr_err pulse chance.
    task automatic runDiv(input int h, input int l, input int n, input int clrPct);
        for (int i = 0; i < n; i++) begin
            genCnt = genCnt % (h + l);
            bus.sig_in = (genCnt < h);
            genCnt++;
            bus.clr_err = (int'($urandom_range(99)) < clrPct);
            applyStimulus();
        end
        bus.clr_err = 1'b0;
    endtask

    task automatic pulseReset();
        rstIn = 1'b1;
        bus.sig_in = 1'b0;
        applyStimulus();
        rstIn = 1'b0;
        genCnt = 0;
    endtask

    initial begin
        int guard;
        rstIn = 1'b1;
        bus.en = 1'b0; bus.sig_in = 1'b0; bus.clr_err = 1'b0;
        bus.exp_high = '0; bus.exp_low = '0;
        applyStimulus();
        applyStimulus();
        rstIn = 1'b0;
        checkOutput("rst_locked", bus.locked, 0);
        checkOutput("rst_err_count", bus.err_count, 0);
        checkOutput("rst_meas_high", bus.meas_high, 0);

        // Divide by 2, expected 1/1
        bus.en = 1'b1; bus.exp_high = 8'd1; bus.exp_low = 8'd1;
        runDiv(1, 1, 40, 0);
        checkOutput("div2_locked", bus.locked, 1);
        checkOutput("div2_err", bus.err, 0);

        // Divide by 4, then tighten exp_low to force a mismatch
        pulseReset();
        bus.exp_high = 8'd2; bus.exp_low = 8'd2;
        runDiv(2, 2, 40, 0);
        checkOutput("div4_locked", bus.locked, 1);
        bus.exp_low = 8'd3;
        runDiv(2, 2, 4, 0);
        checkOutput("div4_mis_err", bus.err, 1);
        checkOutput("div4_mis_count", bus.err_count, 1);
        checkOutput("div4_mis_locked", bus.locked, 0);

        // Divide by 8 against 1/1: err_count saturates
        pulseReset();
        bus.exp_high = 8'd1; bus.exp_low = 8'd1;
        runDiv(4, 4, 260 * 8, 0);
        checkOutput("div8_sat", bus.err_count, SAT);
        bus.en = 1'b0; bus.clr_err = 1'b1;
        applyStimulus();
        bus.clr_err = 1'b0; bus.en = 1'b1;
        checkOutput("clr_err", bus.err, 0);
        checkOutput("clr_count", bus.err_count, 0);

        // Stuck low after lock, then resume and relock
        pulseReset();
        bus.exp_high = 8'd2; bus.exp_low = 8'd2;
        runDiv(2, 2, 40, 0);
        runDiv(0, 1, 250, 0);
        checkOutput("stuck_set", bus.stuck, 1);
        checkOutput("stuck_unlock", bus.locked, 0);
        genCnt = 0;
        runDiv(2, 2, 40, 0);
        checkOutput("relock", bus.locked, 1);
        checkOutput("stuck_hold", bus.stuck, 1);

        // Reset in the middle of a high phase
        guard = 0;
        while (!(genCnt % 4 == 1) && guard < 8) begin
            runDiv(2, 2, 1, 0);
            guard++;
        end
        pulseReset();
        checkOutput("midrst_stuck", bus.stuck, 0);
        checkOutput("midrst_locked", bus.locked, 0);
        runDiv(2, 2, 30, 0);

        // Divide by 28 with an enable drop during the low phase
        pulseReset();
        bus.exp_high = 8'd14; bus.exp_low = 8'd14;
        runDiv(14, 14, 28 * 6, 0);
        checkOutput("div28_locked", bus.locked, 1);
        guard = 0;
        while (bus.sig_in !== 1'b0 && guard < 30) begin
            runDiv(14, 14, 1, 0);
            guard++;
        end
        bus.en = 1'b0;
        runDiv(14, 14, 10, 0);
        checkOutput("en_off_locked", bus.locked, 0);
        bus.en = 1'b1;
        runDiv(14, 14, 28 * 6, 0);
        checkOutput("en_relock", bus.locked, 1);

        // Randomized segments
        for (int seg = 0; seg < 25; seg++) begin
            int h, l;
            h = $urandom_range(12, 1);
            l = $urandom_range(12, 1);
            if ($urandom_range(3) == 0) begin
                bus.exp_high = CNT_W'($urandom_range(12, 1));
                bus.exp_low  = CNT_W'($urandom_range(12, 1));
            end else begin
                bus.exp_high = CNT_W'(h);
                bus.exp_low  = CNT_W'(l);
            end
            if ($urandom_range(9) == 0) begin
                bus.en = 1'b0;
                runDiv(h, l, $urandom_range(5, 1), 0);
                bus.en = 1'b1;
            end
            if ($urandom_range(14) == 0) pulseReset();
            if (seg == 12) runDiv(0, 1, 210, 0);
            runDiv(h, l, $urandom_range(120, 40), 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
